// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and port-slicing / write-arbitration helpers for regfile_sb.
package regfile_pkg;
  localparam int REG_ADDR_WIDTH_DEF = 4;
  localparam int REG_DATA_WIDTH_DEF = 16;
  localparam int REG_NUMBER_DEF = 16;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;
  localparam int MAX_W = 32;
  localparam int MAX_PORTS = 4;
  localparam int MAX_FLAT = MAX_W * MAX_PORTS;
  typedef logic [MAX_FLAT-1:0] flat_t;
  typedef logic [MAX_W-1:0] field_t;
  typedef logic [MAX_PORTS-1:0] port_vec_t;

  function automatic field_t slice_of(flat_t v, int w, int k);
    return field_t'((v >> (w * k)) & ((flat_t'(1) << w) - flat_t'(1)));
  endfunction

  // Highest-index enabled port writing a nonzero address wins; -1 when none.
  function automatic int win_port(port_vec_t en, flat_t addrs, int aw, int n, field_t a);
    int w;
    w = -1;
    for (int j = 0; j < n; j++)
      if (|((en >> j) & port_vec_t'(1)) && a != '0 && slice_of(addrs, aw, j) == a) w = j;
    return w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with WAW issue stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_NUMBER = REG_NUMBER_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic                             iss_en,
  input  logic [REG_ADDR_WIDTH-1:0]        iss_addr,
  output logic                             iss_ready,
  output logic [REG_NUMBER-1:0]            busy_vec
);
  logic [REG_NUMBER-1:0] busy_vec_q, busy_vec_d;

  assign iss_ready = rst && (iss_addr == '0 || !busy_vec_q[iss_addr]);
  assign busy_vec = busy_vec_q;

  // Set is applied after clears so a new producer replaces the retiring one.
  always_comb begin
    busy_vec_d = busy_vec_q;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j]) busy_vec_d[wr_addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] = 1'b0;
    if (iss_en && iss_ready && iss_addr != '0) busy_vec_d[iss_addr] = 1'b1;
    busy_vec_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_vec_q <= '0;
    else busy_vec_q <= busy_vec_d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
  parameter int REG_NUMBER = REG_NUMBER_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*REG_DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*REG_DATA_WIDTH-1:0] wr_data,
  input  logic                             iss_en,
  input  logic [REG_ADDR_WIDTH-1:0]        iss_addr,
  output logic                             iss_ready,
  output logic [REG_NUMBER-1:0]            busy_vec
);
  logic [REG_DATA_WIDTH-1:0] rf_q [REG_NUMBER];
  logic [REG_DATA_WIDTH-1:0] rf_d [REG_NUMBER];
  flat_t     ra_f, wa_f, wd_f;
  port_vec_t we_f;

  assign ra_f = flat_t'(rd_addr);
  assign wa_f = flat_t'(wr_addr);
  assign wd_f = flat_t'(wr_data);
  assign we_f = port_vec_t'(wr_en);

  regfile_scoreboard #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .REG_NUMBER    (REG_NUMBER),
    .NUM_WR        (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ready(iss_ready),
    .busy_vec (busy_vec)
  );

  // Register 0 is never a write target, so it stays at its reset value of zero.
  always_comb begin
    rf_d = rf_q;
    for (int a = 1; a < REG_NUMBER; a++) begin
      int w;
      w = win_port(we_f, wa_f, REG_ADDR_WIDTH, NUM_WR, field_t'(a));
      if (w >= 0) rf_d[a] = REG_DATA_WIDTH'(slice_of(wd_f, REG_DATA_WIDTH, w));
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) rf_q <= '{default: '0};
    else rf_q <= rf_d;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_DATA_WIDTH-1:0] rv;
    logic                      rb;
`ifdef REGFILE_BYPASS_EN
    int fw;
`endif
    assign ra = REG_ADDR_WIDTH'(slice_of(ra_f, REG_ADDR_WIDTH, k));
    always_comb begin
      rv = rf_q[ra];
      rb = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
      fw = win_port(we_f, wa_f, REG_ADDR_WIDTH, NUM_WR, field_t'(ra));
      rv = (fw >= 0) ? REG_DATA_WIDTH'(slice_of(wd_f, REG_DATA_WIDTH, fw)) : rv;
      rb = (fw >= 0) ? 1'b0 : rb;
`endif
    end
    assign rd_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] = (rst && ra != '0) ? rv : '0;
    assign rd_busy[k] = rst && ra != '0 && rb;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Next-generation core register file with multiple read ports and multiple write ports. Adds a per-register pending-write scoreboard so a pipelined issue stage can detect RAW and WAW hazards.
- Sits between decode/issue (read and issue ports) and the writeback stage(s) (write ports).
- Register 0 is hardwired to zero and is never pending.

Parameters:
REG_ADDR_WIDTH, 4, register address width
REG_DATA_WIDTH, 16, register data width
REG_NUMBER, 16, number of registers; must equal 2**REG_ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
rd_addr  input  NUM_RD*REG_ADDR_WIDTH  read addresses; port k uses slice k
rd_data  output  NUM_RD*REG_DATA_WIDTH  read data, combinational
rd_busy  output  NUM_RD  read register has an outstanding write; data not yet valid
wr_en  input  NUM_WR  write enable per port
wr_addr  input  NUM_WR*REG_ADDR_WIDTH  write addresses
wr_data  input  NUM_WR*REG_DATA_WIDTH  write data
iss_en  input  1  issue request: mark iss_addr pending
iss_addr  input  REG_ADDR_WIDTH  destination register of the issuing instruction
iss_ready  output  1  issue accepted this cycle
busy_vec  output  REG_NUMBER  current scoreboard bits, registered

Behaviour:
- Reset (rst low, asynchronous):
  - All registers clear to 0; busy_vec clears to 0.
  - While rst is low: rd_data = 0, rd_busy = 0, iss_ready = 0.
  - Writes and issues are ignored while rst is low.
- Reads:
  - rd_data[k] = 0 and rd_busy[k] = 0 when rd_addr[k] == 0.
  - Otherwise rd_data[k] = rf[rd_addr[k]], modified by bypass (see Optional Feature).
  - rd_busy[k] = busy_vec[rd_addr[k]], modified by bypass.
- Writes:
  - Take effect at the rising clk edge when wr_en[j] = 1 and wr_addr[j] != 0.
  - Writes to address 0 are discarded.
  - Two ports writing the same address in the same cycle: the higher port index wins.
  - A write to a non-pending register is legal: data updates, busy_vec is unchanged.
- Scoreboard:
  - iss_ready = rst && (iss_addr == 0 || !busy_vec[iss_addr]). This is a WAW stall.
  - Accepted issue (iss_en && iss_ready && iss_addr != 0): busy_vec[iss_addr] sets at the next edge.
  - Issue to address 0: iss_ready = 1, no state change.
  - Any wr_en[j] with wr_addr[j] == a clears busy_vec[a] at the edge.
  - Set and clear on the same address in the same cycle: set wins (new producer replaces the old one).
- Latency:
  - Write-to-read through the array: 1 cycle.
  - Scoreboard set/clear: visible 1 cycle after the edge.
- Reset mid-operation: all pending bits drop. Outstanding writebacks that arrive after rst deasserts are plain writes.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - rd_data[k] forwards same-cycle wr_data from the highest-index port with wr_en and matching nonzero address.
  - rd_busy[k] is forced to 0 under a forward.
  - iss_ready is unaffected.
- Undefined:
  - rd_data returns the array value only.
  - rd_busy stays high until the edge after writeback.
  - Read-after-write therefore costs one extra cycle.

Decomposition:
- regfile_pkg holds:
  - default width and count constants;
  - a function to slice a flattened address/data port;
  - a function returning the winning write-port index for an address.
- One sub-module, regfile_scoreboard, owns busy_vec, iss_ready and the set/clear priority.
- The top level holds the storage array, the write arbitration and the read/bypass muxes.

Test Plan:
- Reset with all registers written to 0xFFFF beforehand, then release -> every rd_data = 0x0000, busy_vec = 0, iss_ready = 1.
- Write port0 r3 = 0x1234 and port1 r3 = 0xABCD in the same cycle -> next cycle rd_addr0 = 3 reads 0xABCD.
- Issue r5, then wait 3 cycles -> rd_busy = 1 for r5. Second issue of r5 -> iss_ready = 0. Port1 writes r5 = 0x0042 -> busy_vec[5] = 0 next cycle, iss_ready = 1.
- Issue r7 and write r7 = 0x0011 in the same cycle -> busy_vec[7] = 1, rf[7] = 0x0011.
- With REGFILE_BYPASS_EN: r2 pending, write r2 = 0x5A5A while reading r2 -> same cycle rd_data = 0x5A5A, rd_busy = 0. Without the macro -> old value and rd_busy = 1, then 0x5A5A and rd_busy = 0 next cycle.
- Write r0 = 0xBEEF and issue r0 -> reads of r0 return 0, busy_vec[0] = 0. Assert rst mid-stream with r4 and r9 pending -> all busy bits clear immediately.
